mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Upstream control stage for the 4:1 select-line multiplexer.
- Drives the mux select pair (s1, s0) and enable (en) to scan channels 0..3 in order, dwelling DWELL cycles on each.
- Samples the mux output back on the last dwell cycle of each channel and assembles a 4-bit frame.
- Presents the frame downstream on a valid/ready handshake.

Parameters:
- DWELL, 4, cycles spent on each enabled channel; legal range 1..255; a value of 0 is clamped to 1.
- CNT_W, 8, dwell counter width; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  scan request; sampled only in IDLE.
- mask  in  4  per-channel enable; latched when start is accepted.
- mux_i  in  1  mux output (I) fed back for sampling.
- s1  out  1  mux select bit 1; equals ch[0].
- s0  out  1  mux select bit 0; equals ch[1].
- en  out  1  mux enable; high only while dwelling on an enabled channel.
- frame  out  4  sampled frame; frame[k] holds channel k.
- frame_valid  out  1  frame available.
- frame_ready  in  1  downstream accept.
- busy  out  1  high in SCAN and DONE.

Behaviour:
- All outputs are registered.
- States are IDLE, SCAN, DONE. Internal state: 2-bit ch, CNT_W-bit dwell_cnt, and the latched mask copy mask_q.
- Reset (async assert, any state including mid-scan):
  - state=IDLE; ch=0; dwell_cnt=0; mask_q=0.
  - Outputs: s1=0, s0=0, en=0, frame=0, frame_valid=0, busy=0.
  - A scan in progress is abandoned and no partial frame is emitted.
- IDLE:
  - start=1 at an edge: mask_q<=mask, ch<=0, dwell_cnt<=0, frame<=0, state<=SCAN, busy<=1.
  - start=0: remain in IDLE.
- SCAN, current channel enabled (mask_q[ch]=1):
  - s1=ch[0], s0=ch[1], en=1 for exactly DWELL consecutive cycles.
  - dwell_cnt increments each cycle.
  - On the cycle where dwell_cnt==DWELL-1: frame[ch]<=mux_i, dwell_cnt<=0, ch<=ch+1.
- SCAN, current channel masked (mask_q[ch]=0):
  - Occupies one cycle; en=0, selects still track ch.
  - frame[ch]<=0, ch<=ch+1.
- Leaving SCAN:
  - When channel 3 completes (enabled or masked): state<=DONE, frame_valid<=1, en<=0, s1=s0=0.
  - ch wraps from 3 to 0; it never advances beyond channel 3 within a scan.
- Latency:
  - frame_valid rises N edges after the start-accept edge, where N = DWELL × popcount(mask) + (4 − popcount(mask)).
  - Examples: mask=1111, DWELL=4 gives N=16; mask=0000 gives N=4.
- DONE:
  - frame and frame_valid are held stable until frame_valid & frame_ready at an edge.
  - On that handshake: frame_valid<=0 and the next state follows Optional Feature.
  - frame_ready while not valid is ignored.
- start while busy is ignored; there is no queuing.
- mux_i is sampled only on final dwell cycles; its value at all other times is don't-care.

Optional Feature:
- Macro: SCAN_CONTINUOUS_EN.
- Defined: a DONE handshake immediately re-enters SCAN with the same mask_q (ch=0, dwell_cnt=0, frame<=0). busy stays 1. Only reset returns the block to IDLE.
- Undefined: a DONE handshake returns to IDLE with busy<=0. A new start is required for the next scan.

Test Plan:
- Reset mid-scan: pulse rst_n low during the dwell on ch=2 → outputs return to 0 asynchronously, state is IDLE, no frame_valid pulse follows.
- Full scan: DWELL=4, mask=1111, mux_i held at 1 on ch0 and ch3 only, 0 on ch1 and ch2 → en high for 16 cycles; (s1,s0) steps 00,10,01,11, four cycles each; frame=4'b1001; frame_valid rises 16 edges after the start edge.
- Masked channels: mask=0101, mux_i=1 throughout → frame=4'b0101; en=0 during ch1 and ch3; frame_valid 2×4+2=10 edges after start.
- Empty mask: mask=0000 → en never asserted; frame=0000; frame_valid 4 edges after start.
- Backpressure: hold frame_ready=0 for 5 cycles while valid, then 1 → frame and frame_valid stable throughout; start=1 during the stall is ignored; valid drops one edge after ready; IDLE (macro off) or a new SCAN (macro on) follows.
- DWELL=1 with mask=1111 → each channel selected for one cycle; frame_valid 4 edges after start.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scans the four channels of a 4:1 select-line mux, samples its output, and hands a 4-bit frame downstream.
// Optional macro SCAN_CONTINUOUS_EN: after a frame is accepted, rescan with the same mask instead of idling.
module mux_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       mux_i,
  output logic       s1,
  output logic       s0,
  output logic       en,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam int DWELL_C = (DWELL < 1) ? 1 : DWELL;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_C - 1);

  state_t           state;
  logic [1:0]       ch;
  logic [CNT_W-1:0] dwell_cnt;
  logic [3:0]       mask_q;
  logic [1:0]       ch_inc;
  logic             ch_done;

  assign ch_inc  = ch + 2'd1;
  // A masked channel takes a single cycle; an enabled one finishes on its last dwell cycle.
  assign ch_done = !mask_q[ch] || (dwell_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= 2'd0;
      dwell_cnt   <= '0;
      mask_q      <= 4'd0;
      s1          <= 1'b0;
      s0          <= 1'b0;
      en          <= 1'b0;
      frame       <= 4'd0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask_q    <= mask;
            ch        <= 2'd0;
            dwell_cnt <= '0;
            frame     <= 4'd0;
            state     <= SCAN;
            busy      <= 1'b1;
            s1        <= 1'b0;
            s0        <= 1'b0;
            en        <= mask[0];
          end
        end
        SCAN: begin
          if (ch_done) begin
            frame[ch] <= mask_q[ch] & mux_i;
            dwell_cnt <= '0;
            ch        <= ch_inc;
            if (ch == 2'd3) begin
              state       <= DONE;
              frame_valid <= 1'b1;
              en          <= 1'b0;
              s1          <= 1'b0;
              s0          <= 1'b0;
            end else begin
              s1 <= ch_inc[0];
              s0 <= ch_inc[1];
              en <= mask_q[ch_inc];
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        DONE: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
`ifdef SCAN_CONTINUOUS_EN
            state     <= SCAN;
            ch        <= 2'd0;
            dwell_cnt <= '0;
            frame     <= 4'd0;
            s1        <= 1'b0;
            s0        <= 1'b0;
            en        <= mask_q[0];
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized bench for mux_scan_sequencer: a schedule-based model predicts per-cycle selects, frame and latency.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] mask = 4'd0;
  logic       mux_i = 1'b0;
  logic       frame_ready = 1'b0;

  logic       s1_a, s0_a, en_a, fv_a, busy_a;
  logic [3:0] frame_a;
  logic       s1_b, s0_b, en_b, fv_b, busy_b;
  logic [3:0] frame_b;

  logic       sel_b = 1'b0;
  logic       c_s1, c_s0, c_en, c_fv, c_busy;
  logic [3:0] c_frame;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mux_scan_sequencer #(.DWELL(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .mux_i(mux_i),
    .s1(s1_a), .s0(s0_a), .en(en_a), .frame(frame_a), .frame_valid(fv_a),
    .frame_ready(frame_ready), .busy(busy_a)
  );

  mux_scan_sequencer #(.DWELL(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .mux_i(mux_i),
    .s1(s1_b), .s0(s0_b), .en(en_b), .frame(frame_b), .frame_valid(fv_b),
    .frame_ready(frame_ready), .busy(busy_b)
  );

  assign c_s1    = sel_b ? s1_b    : s1_a;
  assign c_s0    = sel_b ? s0_b    : s0_a;
  assign c_en    = sel_b ? en_b    : en_a;
  assign c_fv    = sel_b ? fv_b    : fv_a;
  assign c_busy  = sel_b ? busy_b  : busy_a;
  assign c_frame = sel_b ? frame_b : frame_a;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    frame_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({c_s1, c_s0, c_en, c_frame, c_fv, c_busy} !== 9'd0)
      $display("FAIL reset_outputs: got %b expected 000000000", {c_s1, c_s0, c_en, c_frame, c_fv, c_busy});
    else passed++;
    rst_n = 1'b1;
  endtask

  // Drives one complete scan and handshake; the expected behaviour comes from a per-cycle schedule.
  task automatic do_scan(input string name, input logic [3:0] m, input logic [3:0] vals,
                         input bit noise, input int stall);
    int dw = sel_b ? 1 : 4;
    int  sch_ch[$];
    bit  sch_en[$];
    bit  sch_last[$];
    logic [3:0] exp_frame = vals & m;
    int n;
    int bad;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        for (int d = 0; d < dw; d++) begin
          sch_ch.push_back(k); sch_en.push_back(1'b1); sch_last.push_back(d == dw - 1);
        end
      end else begin
        sch_ch.push_back(k); sch_en.push_back(1'b0); sch_last.push_back(1'b1);
      end
    end
    n = sch_ch.size();
    @(negedge clk);
    start = 1'b1;
    mask  = m;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mask  = 4'($urandom);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (c_en !== sch_en[i] || c_s1 !== sch_ch[i][0] || c_s0 !== sch_ch[i][1] ||
          c_fv !== 1'b0 || c_busy !== 1'b1) begin
        if (bad < 4)
          $display("FAIL %s_cycle%0d: got en=%b s1=%b s0=%b fv=%b busy=%b expected en=%b s1=%b s0=%b fv=0 busy=1",
                   name, i, c_en, c_s1, c_s0, c_fv, c_busy, sch_en[i], sch_ch[i][0], sch_ch[i][1]);
        bad++;
      end
      mux_i = (sch_last[i] || !noise) ? vals[sch_ch[i]] : 1'($urandom);
    end
    total++;
    if (bad == 0) passed++;
    @(negedge clk);
    total++;
    if (c_fv !== 1'b1 || c_frame !== exp_frame || c_en !== 1'b0 || c_s1 !== 1'b0 || c_s0 !== 1'b0) begin
      $display("FAIL %s_done: got fv=%b frame=%b en=%b sel=%b%b after %0d edges expected fv=1 frame=%b en=0 sel=00",
               name, c_fv, c_frame, c_en, c_s1, c_s0, n, exp_frame);
    end else passed++;
    bad = 0;
    for (int j = 0; j < stall; j++) begin
      start = 1'b1;
      mask  = 4'($urandom);
      frame_ready = 1'b0;
      @(negedge clk);
      if (c_fv !== 1'b1 || c_frame !== exp_frame || c_busy !== 1'b1) bad++;
    end
    if (stall > 0) begin
      total++;
      if (bad != 0) $display("FAIL %s_stall: %0d unstable cycles expected 0", name, bad);
      else passed++;
    end
    start = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    total++;
`ifdef SCAN_CONTINUOUS_EN
    if (c_fv !== 1'b0 || c_busy !== 1'b1 || c_en !== m[0] || c_frame !== 4'd0)
      $display("FAIL %s_handshake: got fv=%b busy=%b en=%b frame=%b expected fv=0 busy=1 en=%b frame=0000",
               name, c_fv, c_busy, c_en, c_frame, m[0]);
`else
    if (c_fv !== 1'b0 || c_busy !== 1'b0 || c_en !== 1'b0)
      $display("FAIL %s_handshake: got fv=%b busy=%b en=%b expected fv=0 busy=0 en=0",
               name, c_fv, c_busy, c_en);
`endif
    else passed++;
    $display("scan %s dwell=%0d mask=%b vals=%b frame=%b edges=%0d stall=%0d", name, dw, m, vals, c_frame, n, stall);
  endtask

  task automatic test_reset();
    int bad = 0;
    sel_b = 1'b0;
    apply_reset();
    @(negedge clk);
    start = 1'b1;
    mask  = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    total++;
    if (c_en !== 1'b1 || c_s1 !== 1'b0 || c_s0 !== 1'b1)
      $display("FAIL reset_pre_ch2: got en=%b s1=%b s0=%b expected en=1 s1=0 s0=1", c_en, c_s1, c_s0);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({c_s1, c_s0, c_en, c_frame, c_fv, c_busy} !== 9'd0)
      $display("FAIL reset_async: got %b expected 000000000", {c_s1, c_s0, c_en, c_frame, c_fv, c_busy});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (c_fv !== 1'b0 || c_busy !== 1'b0 || c_en !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL reset_no_frame: %0d bad cycles expected 0", bad);
    else passed++;
    $display("reset mid-scan checked");
  endtask

  task automatic test_full_scan();
    sel_b = 1'b0;
    apply_reset();
    do_scan("full", 4'b1111, 4'b1001, 1'b0, 0);
  endtask

  task automatic test_masked();
    sel_b = 1'b0;
    apply_reset();
    do_scan("masked", 4'b0101, 4'b1111, 1'b0, 0);
  endtask

  task automatic test_empty();
    sel_b = 1'b0;
    apply_reset();
    do_scan("empty", 4'b0000, 4'b1111, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    sel_b = 1'b0;
    apply_reset();
    do_scan("stall", 4'b1011, 4'($urandom), 1'b1, 5);
  endtask

  task automatic test_dwell1();
    sel_b = 1'b1;
    apply_reset();
    do_scan("dwell1", 4'b1111, 4'b0110, 1'b0, 0);
    sel_b = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      sel_b = r[0];
      apply_reset();
      do_scan("rand", 4'($urandom), 4'($urandom), 1'b1, int'($urandom_range(0, 3)));
      if (r % 2 == 0) begin
        // back-to-back scan without an intervening reset
`ifndef SCAN_CONTINUOUS_EN
        do_scan("b2b", 4'($urandom), 4'($urandom), 1'b1, 0);
`endif
      end
    end
    sel_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_masked();
    test_empty();
    test_backpressure();
    test_dwell1();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
